// File: rtl/gated_deser_rx.sv
`default_nettype none
// ============================================================================
// Module      : gated_deser_rx
// Description : Start-strobed, LSB-first serial-to-parallel receiver whose
//               one-cycle word release is zeroed by a registered mask.
// Revision    : 1.0 - initial release
// ============================================================================
module gated_deser_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_start_i,
    input  logic             rx_bit_i,
    input  logic             mask_i,
    output logic [WIDTH-1:0] out_data_o,
    output logic             out_valid_o,
    output logic             overrun_o
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_t             state_q,    state_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   shreg_q,    shreg_d;
    logic               done_q,     done_d;
    logic               mask_lat_q, mask_lat_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q,  overrun_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            done_q      <= 1'b0;
            mask_lat_q  <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            done_q      <= done_d;
            mask_lat_q  <= mask_lat_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        done_d      = 1'b0;
        mask_lat_d  = mask_lat_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        overrun_d   = overrun_q;

        // Release runs independently of framing so a new start can overlap it.
        if (done_q) begin
            out_data_d  = mask_lat_q ? '0 : shreg_q;
            out_valid_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (rx_start_i) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end
            end
            S_SHIFT: begin
                shreg_d = {rx_bit_i, shreg_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                if (rx_start_i) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == C_LAST) begin
                    done_d     = 1'b1;
                    mask_lat_d = mask_i;
                    state_d    = S_IDLE;
                    cnt_d      = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data_o  = out_data_q;
    assign out_valid_o = out_valid_q;
    assign overrun_o   = overrun_q;

endmodule
`default_nettype wire
